// File: rtl/pe_mac_mp_if.sv
// Bus bundle for the mixed-precision MAC PE: operand/forward path,
// control strobes, and the drained-result handshake.
interface pe_mac_mp_if #(
  parameter int unsigned ELEM_BITS = 8,
  parameter int unsigned ACC_BITS  = 32
);
  logic                        clr;
  logic                        shift_en;
  logic [1:0]                  mode;
  logic [ELEM_BITS-1:0]        a_in;
  logic [ELEM_BITS-1:0]        b_in;
  logic                        a_v_in;
  logic                        b_v_in;
  logic                        last_in;
  logic [ELEM_BITS-1:0]        a_out;
  logic [ELEM_BITS-1:0]        b_out;
  logic                        a_v_out;
  logic                        b_v_out;
  logic signed [ACC_BITS-1:0]  c_out;
  logic                        c_valid;
  logic                        c_ready;
  logic                        sat_flag;
  logic                        ovf_err;

  // PE side
  modport slave (
    input  clr, shift_en, mode, a_in, b_in, a_v_in, b_v_in, last_in, c_ready,
    output a_out, b_out, a_v_out, b_v_out, c_out, c_valid, sat_flag, ovf_err
  );

  // Driver / fabric side
  modport master (
    output clr, shift_en, mode, a_in, b_in, a_v_in, b_v_in, last_in, c_ready,
    input  a_out, b_out, a_v_out, b_v_out, c_out, c_valid, sat_flag, ovf_err
  );
endinterface

// File: rtl/pe_mac_mp.sv
// Two-stage mixed-precision MAC PE (INT8 signed/unsigned, dual INT4) with
// optional saturating accumulator, operand forwarding and a drained
// valid/ready result register.
module pe_mac_mp #(
  parameter int unsigned ELEM_BITS = 8,
  parameter int unsigned ACC_BITS  = 32,
  parameter bit          SAT_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  pe_mac_mp_if.slave   bus
);
  localparam int unsigned P = 2 * ELEM_BITS + 1;
  localparam int unsigned H = ELEM_BITS / 2;
  localparam int unsigned W = ACC_BITS + 1;

  typedef enum logic [1:0] {
    MODE_S8   = 2'd0,
    MODE_U8   = 2'd1,
    MODE_S4X2 = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  logic [ELEM_BITS-1:0]       a_out_q, b_out_q;
  logic                       a_v_out_q, b_v_out_q;
  logic signed [P-1:0]        prod_d, prod_q;
  logic                       s1_v_d, s1_v_q, s1_last_d, s1_last_q;
  logic signed [ACC_BITS-1:0] acc_d, acc_q, c_out_d, c_out_q;
  logic                       c_valid_d, c_valid_q;
  logic                       sat_d, sat_q, ovf_d, ovf_q;
  logic signed [P-1:0]        ax, bx, ahx, bhx;
  logic signed [W-1:0]        sum_w;
  logic signed [ACC_BITS-1:0] sum_c;
  logic                       sat_hit, hs;

  // Operand forwarding to the neighbouring PE, gated by shift_en only
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q   <= '0;
      b_out_q   <= '0;
      a_v_out_q <= 1'b0;
      b_v_out_q <= 1'b0;
    end else if (bus.shift_en) begin
      a_out_q   <= bus.a_in;
      b_out_q   <= bus.b_in;
      a_v_out_q <= bus.a_v_in;
      b_v_out_q <= bus.b_v_in;
    end
  end

  // Stage-1 product selection by precision mode (mode 3 aliases mode 0)
  always_comb begin
    ax     = '0;
    bx     = '0;
    ahx    = '0;
    bhx    = '0;
    prod_d = '0;
    case (mode_e'(bus.mode))
      MODE_U8: begin
        ax     = P'(bus.a_in);
        bx     = P'(bus.b_in);
        prod_d = ax * bx;
      end
      MODE_S4X2: begin
        ahx    = P'($signed(bus.a_in[ELEM_BITS-1:H]));
        bhx    = P'($signed(bus.b_in[ELEM_BITS-1:H]));
        ax     = P'($signed(bus.a_in[H-1:0]));
        bx     = P'($signed(bus.b_in[H-1:0]));
        prod_d = ahx * bhx + ax * bx;
      end
      default: begin
        ax     = P'($signed(bus.a_in));
        bx     = P'($signed(bus.b_in));
        prod_d = ax * bx;
      end
    endcase
    s1_v_d    = bus.a_v_in & bus.b_v_in;
    s1_last_d = bus.last_in & s1_v_d;
  end

  // Stage-1 pipeline register; clr kills the in-flight term
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      s1_v_q    <= s1_v_d & ~bus.clr;
      s1_last_q <= s1_last_d & ~bus.clr;
    end
  end

  // Stage-2 add with one guard bit; overflow shows as guard/MSB disagreement
  always_comb begin
    sum_w   = W'(acc_q) + W'(prod_q);
    sum_c   = sum_w[ACC_BITS-1:0];
    sat_hit = 1'b0;
    if (SAT_EN && (sum_w[W-1] != sum_w[W-2])) begin
      sat_hit = 1'b1;
      sum_c   = sum_w[W-1] ? {1'b1, {(ACC_BITS-1){1'b0}}}
                           : {1'b0, {(ACC_BITS-1){1'b1}}};
    end
  end

  // Accumulate/drain/handshake next state; clr wins over accumulate and drain
  always_comb begin
    acc_d     = acc_q;
    c_out_d   = c_out_q;
    c_valid_d = c_valid_q;
    sat_d     = sat_q;
    ovf_d     = ovf_q;
    hs        = c_valid_q & bus.c_ready;
    if (hs) c_valid_d = 1'b0;
    if (bus.clr) begin
      acc_d = '0;
      sat_d = 1'b0;
      ovf_d = 1'b0;
    end else if (s1_v_q) begin
      if (sat_hit) sat_d = 1'b1;
      if (s1_last_q) begin
        c_out_d   = sum_c;
        c_valid_d = 1'b1;
        acc_d     = '0;
        if (c_valid_q && !bus.c_ready) ovf_d = 1'b1;
      end else begin
        acc_d = sum_c;
      end
    end
  end

  // Stage-2 and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      c_out_q   <= '0;
      c_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      c_out_q   <= c_out_d;
      c_valid_q <= c_valid_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.a_out    = a_out_q;
  assign bus.b_out    = b_out_q;
  assign bus.a_v_out  = a_v_out_q;
  assign bus.b_v_out  = b_v_out_q;
  assign bus.c_out    = c_out_q;
  assign bus.c_valid  = c_valid_q;
  assign bus.sat_flag = sat_q;
  assign bus.ovf_err  = ovf_q;
endmodule

// File: tb/tb_pe_mac_mp.sv
// Directed bench for pe_mac_mp: three instances (32-bit saturating,
// 20-bit saturating, 20-bit wrapping) share one stimulus stream.
module tb_pe_mac_mp;
  logic       clk = 1'b0;
  logic       rst;
  logic       clr_r, shift_r, ready_r, av_r, bv_r, last_r;
  logic [1:0] mode_r;
  logic [7:0] a_r, b_r;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] ea, eb;
  logic       eav, ebv;

  always #5 clk = ~clk;

  pe_mac_mp_if #(.ELEM_BITS(8), .ACC_BITS(32)) if_a ();
  pe_mac_mp_if #(.ELEM_BITS(8), .ACC_BITS(20)) if_b ();
  pe_mac_mp_if #(.ELEM_BITS(8), .ACC_BITS(20)) if_c ();

  assign if_a.clr = clr_r;     assign if_b.clr = clr_r;     assign if_c.clr = clr_r;
  assign if_a.shift_en = shift_r; assign if_b.shift_en = shift_r; assign if_c.shift_en = shift_r;
  assign if_a.mode = mode_r;   assign if_b.mode = mode_r;   assign if_c.mode = mode_r;
  assign if_a.a_in = a_r;      assign if_b.a_in = a_r;      assign if_c.a_in = a_r;
  assign if_a.b_in = b_r;      assign if_b.b_in = b_r;      assign if_c.b_in = b_r;
  assign if_a.a_v_in = av_r;   assign if_b.a_v_in = av_r;   assign if_c.a_v_in = av_r;
  assign if_a.b_v_in = bv_r;   assign if_b.b_v_in = bv_r;   assign if_c.b_v_in = bv_r;
  assign if_a.last_in = last_r; assign if_b.last_in = last_r; assign if_c.last_in = last_r;
  assign if_a.c_ready = ready_r; assign if_b.c_ready = ready_r; assign if_c.c_ready = ready_r;

  pe_mac_mp #(.ELEM_BITS(8), .ACC_BITS(32), .SAT_EN(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  pe_mac_mp #(.ELEM_BITS(8), .ACC_BITS(20), .SAT_EN(1'b1)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
  pe_mac_mp #(.ELEM_BITS(8), .ACC_BITS(20), .SAT_EN(1'b0)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Present one operand pair for one cycle, then return to idle
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input logic [1:0] m);
    a_r = a; b_r = b; av_r = 1'b1; bv_r = 1'b1; last_r = last; mode_r = m;
    @(negedge clk);
    av_r = 1'b0; bv_r = 1'b0; last_r = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_r = 1'b0; shift_r = 1'b1; ready_r = 1'b0;
    av_r = 1'b0; bv_r = 1'b0; last_r = 1'b0; mode_r = 2'd0; a_r = 8'h00; b_r = 8'h00;
    cyc(2);
    chk("rst_c_out",   longint'(if_a.c_out), 0);
    chk("rst_c_valid", longint'(if_a.c_valid), 0);
    chk("rst_sat",     longint'(if_a.sat_flag), 0);
    chk("rst_ovf",     longint'(if_a.ovf_err), 0);
    chk("rst_a_v_out", longint'(if_a.a_v_out), 0);
    rst = 1'b0;
    cyc(1);

    // mode 0: 16384 - 127
    send(8'h80, 8'h80, 1'b0, 2'd0);
    send(8'h7F, 8'hFF, 1'b1, 2'd0);
    cyc(1);
    chk("m0_c_out",   longint'(if_a.c_out), 16257);
    chk("m0_c_valid", longint'(if_a.c_valid), 1);
    chk("m0_sat",     longint'(if_a.sat_flag), 0);
    ready_r = 1'b1;
    cyc(1);
    chk("hs_c_valid_drop", longint'(if_a.c_valid), 0);
    chk("hs_c_out_hold",   longint'(if_a.c_out), 16257);

    // mode 1 (also shows acc restarted at 0)
    send(8'hFF, 8'hFF, 1'b1, 2'd1);
    cyc(1);
    chk("m1_c_out", longint'(if_a.c_out), 65025);

    // back-to-back dot products, second drain coincides with handshake
    send(8'd3, 8'd4, 1'b1, 2'd0);
    send(8'd5, 8'd6, 1'b1, 2'd0);
    chk("b2b_first", longint'(if_a.c_out), 12);
    cyc(1);
    chk("b2b_second",  longint'(if_a.c_out), 30);
    chk("b2b_c_valid", longint'(if_a.c_valid), 1);
    chk("b2b_no_ovf",  longint'(if_a.ovf_err), 0);

    // mode 2 and reserved mode 3
    send(8'h3F, 8'h2E, 1'b1, 2'd2);
    cyc(1);
    chk("m2_c_out", longint'(if_a.c_out), 8);
    send(8'hFF, 8'h02, 1'b1, 2'd3);
    cyc(1);
    chk("m3_c_out", longint'(if_a.c_out), -2);

    // saturation at ACC_BITS=20: 32 * 16384 = 2^19
    for (int i = 0; i < 32; i++) send(8'h80, 8'h80, (i == 31), 2'd0);
    cyc(1);
    chk("sat_c_out",   longint'(if_b.c_out), 524287);
    chk("sat_flag",    longint'(if_b.sat_flag), 1);
    chk("wrap_c_out",  longint'(if_c.c_out), -524288);
    chk("wrap_flag",   longint'(if_c.sat_flag), 0);
    chk("wide_c_out",  longint'(if_a.c_out), 524288);
    chk("wide_flag",   longint'(if_a.sat_flag), 0);
    clr_r = 1'b1;
    cyc(1);
    clr_r = 1'b0;
    chk("clr_sat_flag", longint'(if_b.sat_flag), 0);

    // back-pressure overwrite
    ready_r = 1'b0;
    send(8'd2, 8'd3, 1'b1, 2'd0);
    send(8'd4, 8'd5, 1'b1, 2'd0);
    chk("bp_first",     longint'(if_a.c_out), 6);
    chk("bp_first_ovf", longint'(if_a.ovf_err), 0);
    cyc(1);
    chk("bp_c_out",   longint'(if_a.c_out), 20);
    chk("bp_ovf",     longint'(if_a.ovf_err), 1);
    chk("bp_c_valid", longint'(if_a.c_valid), 1);
    ready_r = 1'b1;
    cyc(1);
    chk("bp_release_valid", longint'(if_a.c_valid), 0);
    chk("bp_ovf_sticky",    longint'(if_a.ovf_err), 1);

    // clr mid dot product, also dropping the pair sent with clr
    send(8'd1, 8'd2, 1'b0, 2'd0);
    send(8'd3, 8'd4, 1'b0, 2'd0);
    send(8'd5, 8'd6, 1'b0, 2'd0);
    clr_r = 1'b1;
    send(8'd9, 8'd9, 1'b0, 2'd0);
    clr_r = 1'b0;
    ready_r = 1'b0;
    send(8'd1, 8'd1, 1'b1, 2'd0);
    cyc(1);
    chk("clr_c_out", longint'(if_a.c_out), 1);
    chk("clr_ovf",   longint'(if_a.ovf_err), 0);
    chk("clr_sat",   longint'(if_a.sat_flag), 0);
    clr_r = 1'b1;
    cyc(1);
    clr_r = 1'b0;
    chk("clr_keeps_valid", longint'(if_a.c_valid), 1);
    chk("clr_keeps_c_out", longint'(if_a.c_out), 1);

    // rst with pending result and a pair in flight
    send(8'd6, 8'd6, 1'b0, 2'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst2_c_out",   longint'(if_a.c_out), 0);
    chk("rst2_c_valid", longint'(if_a.c_valid), 0);
    chk("rst2_a_out",   longint'(if_a.a_out), 0);
    chk("rst2_b_out",   longint'(if_a.b_out), 0);
    ready_r = 1'b1;
    send(8'd3, 8'd3, 1'b1, 2'd0);
    cyc(1);
    chk("rst2_fresh_sum", longint'(if_a.c_out), 9);

    // forward path with random operands, shift_en and clr
    for (int i = 0; i < 24; i++) begin
      a_r     = 8'($urandom);
      b_r     = 8'($urandom);
      av_r    = 1'($urandom);
      bv_r    = 1'($urandom);
      shift_r = (i == 0) ? 1'b1 : 1'($urandom);
      clr_r   = 1'($urandom);
      mode_r  = 2'($urandom);
      last_r  = 1'b0;
      if (shift_r) begin
        ea = a_r; eb = b_r; eav = av_r; ebv = bv_r;
      end
      @(negedge clk);
      chk("fwd_a_out",   longint'(if_a.a_out), longint'(ea));
      chk("fwd_b_out",   longint'(if_a.b_out), longint'(eb));
      chk("fwd_a_v_out", longint'(if_a.a_v_out), longint'(eav));
      chk("fwd_b_v_out", longint'(if_a.b_v_out), longint'(ebv));
    end
    shift_r = 1'b1; clr_r = 1'b0; av_r = 1'b0; bv_r = 1'b0;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
